// File: rtl/sdc_frame_serdes.sv
// Full-duplex frame shifter for the FPGA-to-SDC link. A parallel TX frame
// is loaded through a valid/ready handshake and then shifted one bit per
// shift_en strobe. Each strobe sends one bit and captures one incoming bit.
// At frame end the captured frame is latched into rx_frame and frame_done
// pulses for one cycle.
module sdc_frame_serdes #(
  parameter int NBYTES    = 6,
  parameter int BYTE_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = NBYTES * BYTE_W,
  localparam int CW       = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  input  logic          shift_en,
  input  logic          serial_in,
  output logic          serial_out,
  input  logic          abort,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic [W-1:0]  rx_frame,
  output logic          frame_done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W-1:0]  shift_nxt;
  logic          last_bit;

  assign last_bit = (cnt_q == CW'(W - 1));

  // Shift register contents after one strobe, in the configured bit order.
  // The outgoing bit leaves one end while the incoming bit enters the other.
  always_comb begin
    if (MSB_FIRST) shift_nxt = {shreg_q[W-2:0], serial_in};
    else           shift_nxt = {serial_in, shreg_q[W-1:1]};
  end

  // Next-state logic. abort wins over a same-cycle strobe, including the
  // final one, so an aborted frame never reaches rx_frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (shift_en) begin
          shreg_d = shift_nxt;
          if (last_bit) begin
            rx_d    = shift_nxt;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign load_ready = (state_q == IDLE);
  assign serial_out = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];
  assign bit_cnt    = cnt_q;
  assign rx_frame   = rx_q;
  assign frame_done = done_q;

endmodule
